risc_core: RTL and testbench

//  Parametrised multicycle accumulator-less RISC core. Next generation of the 8-bit CPU.

---
 rtl/risc_core_pkg.sv | 13 +
 rtl/risc_core_alu.sv | 38 +++
 rtl/risc_core.sv | 112 +++++++++++
 tb/tb_risc_core.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_core_pkg.sv
// risc_core_pkg: opcodes, FSM states and instruction field extractors shared by risc_core
// No ports. Insn word layout: op = [DW-1:DW-4], src = [2*RW-1:RW], dst = [RW-1:0].
package risc_core_pkg;
  localparam logic [3:0] OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3, OP_NOT = 4'd4;
  localparam logic [3:0] OP_RD = 4'd5, OP_WR = 4'd6, OP_BR = 4'd7, OP_BRZ = 4'd8, OP_BRC = 4'd9;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_OPND, S_MEMRD, S_MEMWR, S_HALT} state_e;
  function automatic logic [3:0] insn_op(input logic [63:0] w, input int dw);
    return w[dw-1 -: 4];
  endfunction
  function automatic logic [31:0] insn_reg(input logic [63:0] w, input int lsb, input int rw);
    return 32'((w >> lsb) & ((64'd1 << rw) - 64'd1));
  endfunction
endpackage

// File: rtl/risc_core_alu.sv
// risc_core_alu: combinational ALU for risc_core (ADD, SUB, AND, NOT)
// Ports: op_i opcode, a_i = R[src], b_i = R[dst], y_o result, z_o result==0,
//        c_o carry/borrow (present only with RISC_CORE_CARRY_EN defined).
module risc_core_alu
  import risc_core_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    op_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] y_o,
  output logic          z_o
`ifdef RISC_CORE_CARRY_EN
  ,
  output logic          c_o
`endif
);
`ifdef RISC_CORE_CARRY_EN
  localparam int XW = DW + 1;
`else
  localparam int XW = DW;
`endif
  logic [XW-1:0] sum, diff;
  assign sum  = XW'(b_i) + XW'(a_i);
  assign diff = XW'(b_i) - XW'(a_i);
  always_comb begin
    y_o = op_i == OP_ADD ? sum[DW-1:0] :
          op_i == OP_SUB ? diff[DW-1:0] :
          op_i == OP_AND ? a_i & b_i :
          op_i == OP_NOT ? ~a_i : '0;
    z_o = y_o == '0;
  end
`ifdef RISC_CORE_CARRY_EN
  // the extra top bit of the widened sum/difference is carry-out / borrow
  assign c_o = op_i == OP_ADD ? sum[DW] : op_i == OP_SUB ? diff[DW] : 1'b0;
`endif
endmodule

// File: rtl/risc_core.sv
// risc_core: parametrised multicycle RISC core with req/ack memory port, halts on illegal opcodes
// Ports: clk, reset (sync, active-high); mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ack in;
//        halted (core in HALT), pc_o (current PC, debug).
// Config: RISC_CORE_CARRY_EN adds the C flag and BRC; otherwise opcode 9 is illegal.
module risc_core
  import risc_core_pkg::*;
#(
  parameter int DW       = 8,
  parameter int AW       = 8,
  parameter int NREGS    = 4,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          reset,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          halted,
  output logic [AW-1:0] pc_o
);
  localparam int RW = $clog2(NREGS);
  state_e state_q, state_d;
  logic [AW-1:0] pc_q, ar_q;
  logic [DW-1:0] ir_q;
  logic [DW-1:0] regs_q [NREGS];
  logic z_q;
  logic [3:0] op;
  logic [RW-1:0] src, dst;
  logic [DW-1:0] alu_y;
  logic alu_z, legal, c_set, is_alu, is_br, br_skip;
  assign op     = insn_op(64'(ir_q), DW);
  assign src    = RW'(insn_reg(64'(ir_q), RW, RW));
  assign dst    = RW'(insn_reg(64'(ir_q), 0, RW));
  assign is_alu = op inside {OP_ADD, OP_SUB, OP_AND, OP_NOT};
  assign is_br  = op inside {OP_BR, OP_BRZ, OP_BRC};
`ifdef RISC_CORE_CARRY_EN
  logic c_q, alu_c;
  assign legal = op <= OP_BRC;
  assign c_set = c_q;
`else
  assign legal = op <= OP_BRZ;
  assign c_set = 1'b0;
`endif
  // a conditional branch whose flag is clear skips its operand word
  assign br_skip = (op == OP_BRZ && !z_q) || (op == OP_BRC && !c_set);
  risc_core_alu #(.DW(DW)) u_alu (
    .op_i(op),
    .a_i (regs_q[src]),
    .b_i (regs_q[dst]),
    .y_o (alu_y),
    .z_o (alu_z)
`ifdef RISC_CORE_CARRY_EN
    ,
    .c_o (alu_c)
`endif
  );
  always_ff @(posedge clk) state_q <= reset ? S_FETCH : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:          state_d = mem_ack ? S_DECODE : S_FETCH;
      S_DECODE:         state_d = !legal ? S_HALT : is_alu ? S_EXEC :
                                  (is_br && !br_skip) || op inside {OP_RD, OP_WR} ? S_OPND : S_FETCH;
      S_EXEC:           state_d = S_FETCH;
      S_OPND:           state_d = !mem_ack ? S_OPND : op == OP_RD ? S_MEMRD : op == OP_WR ? S_MEMWR : S_FETCH;
      S_MEMRD, S_MEMWR: state_d = mem_ack ? S_FETCH : state_q;
      default:          state_d = S_HALT;
    endcase
  end
  // reset gates the request at once so an access in flight never completes
  always_comb begin
    mem_req   = !reset && state_q inside {S_FETCH, S_OPND, S_MEMRD, S_MEMWR};
    mem_we    = !reset && state_q == S_MEMWR;
    mem_addr  = state_q inside {S_MEMRD, S_MEMWR} ? ar_q : pc_q;
    mem_wdata = regs_q[src];
    halted    = state_q == S_HALT;
  end
  assign pc_o = pc_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= AW'(RESET_PC);
      ar_q   <= '0;
      ir_q   <= '0;
      z_q    <= 1'b0;
      regs_q <= '{default: '0};
    end else begin
      case (state_q)
        S_FETCH:  if (mem_ack) begin
          ir_q <= mem_rdata;
          pc_q <= pc_q + AW'(1);
        end
        S_DECODE: if (legal && br_skip) pc_q <= pc_q + AW'(1);
        S_EXEC: begin
          regs_q[dst] <= alu_y;
          z_q         <= alu_z;
        end
        S_OPND:   if (mem_ack) begin
          ar_q <= mem_rdata[AW-1:0];
          pc_q <= is_br ? mem_rdata[AW-1:0] : pc_q + AW'(1);
        end
        S_MEMRD:  if (mem_ack) regs_q[dst] <= mem_rdata;
        default: ;
      endcase
    end
  end
`ifdef RISC_CORE_CARRY_EN
  always_ff @(posedge clk) c_q <= reset ? 1'b0 : state_q == S_EXEC ? alu_c : c_q;
`endif
endmodule

// File: tb/tb_risc_core.sv
// tb_risc_core: randomized and directed self-checking bench for risc_core against an ISA-level model
module tb_risc_core;
`ifdef RISC_CORE_CARRY_EN
  localparam bit CARRY = 1'b1;
`else
  localparam bit CARRY = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, mem_ack = 1'b0;
  logic mem_req, mem_we, halted;
  logic [7:0] mem_addr, mem_wdata, pc_o;
  logic [7:0] mem_rdata = '0;
  logic [7:0] mem [256];
  logic [7:0] mm [256];
  logic [7:0] init [256];
  logic [15:0] wlog [$];
  logic [7:0] rlog [$];
  int npass = 0, ntotal = 0, waits = 0, max_wait = 0, wleft = 0;
  int m_cyc, m_nw;
  logic [7:0] m_pc;
  bit open = 0, hold_wr = 0;
  logic [7:0] la, ld;
  logic lw;
  risc_core dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .halted(halted), .pc_o(pc_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntotal++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [7:0] enc(input int op, input int s, input int d);
    return 8'((op << 4) | (s << 2) | d);
  endfunction
  always @(negedge clk) begin
    if (mem_req) begin
      if (!open) begin
        open = 1;
        la = mem_addr;
        lw = mem_we;
        ld = mem_wdata;
        wleft = max_wait > 0 ? int'($urandom_range(max_wait, 0)) : 0;
      end else begin
        chk("stable_addr", mem_addr, la);
        chk("stable_we", mem_we, lw);
        if (lw) chk("stable_wdata", mem_wdata, ld);
      end
      mem_ack = wleft == 0 && !(hold_wr && mem_we);
      if (wleft > 0) wleft--;
      mem_rdata = mem[mem_addr];
      if (!mem_ack) waits++;
    end else begin
      open = 0;
      mem_ack = 0;
    end
  end
  always @(posedge clk) if (mem_req && mem_ack) begin
    open = 0;
    if (mem_we) begin
      mem[mem_addr] = mem_wdata;
      wlog.push_back({mem_addr, mem_wdata});
    end else rlog.push_back(mem_addr);
  end
  task automatic model();
    logic [7:0] r [4];
    logic [7:0] ins, a;
    logic z, c;
    int op, s, d, x, y, t;
    for (int i = 0; i < 256; i++) mm[i] = init[i];
    r = '{default: 0};
    z = 0; c = 0; m_pc = 0; m_cyc = 0; m_nw = 0;
    for (int step = 0; step < 3000; step++) begin
      ins = mm[m_pc]; m_pc++;
      op = int'(ins[7:4]); s = int'(ins[3:2]); d = int'(ins[1:0]);
      if (op == 0) m_cyc += 2;
      else if (op <= 4) begin
        x = int'(r[d]); y = int'(r[s]);
        t = op == 1 ? x + y : op == 2 ? x - y : op == 3 ? x & y : ~y;
        c = op == 1 ? t > 255 : op == 2 ? t < 0 : 1'b0;
        r[d] = 8'(t);
        z = r[d] == 0;
        m_cyc += 3;
      end else if (op == 5) begin
        a = mm[m_pc]; m_pc++; r[d] = mm[a]; m_cyc += 4;
      end else if (op == 6) begin
        a = mm[m_pc]; m_pc++; mm[a] = r[s]; m_nw++; m_cyc += 4;
      end else if (op == 7 || (op == 8 && z) || (op == 9 && CARRY && c)) begin
        m_pc = mm[m_pc]; m_cyc += 3;
      end else if (op == 8 || (op == 9 && CARRY)) begin
        m_pc++; m_cyc += 2;
      end else begin
        m_cyc += 2;
        return;
      end
    end
  endtask
  task automatic run(input int maxw, output int cyc);
    max_wait = maxw;
    reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_halted", halted, 0);
    wlog.delete(); rlog.delete(); waits = 0;
    @(posedge clk);
    #1 reset = 0;
    cyc = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("boot_req", mem_req, 1);
        chk("boot_addr", mem_addr, 0);
      end
      if (halted) break;
      cyc++;
    end
  endtask
  task automatic exec(input int maxw, output int cyc);
    int post;
    for (int i = 0; i < 256; i++) init[i] = mem[i];
    model();
    run(maxw, cyc);
    chk("cycles", cyc, m_cyc + waits);
    chk("halted", halted, 1);
    chk("pc", pc_o, m_pc);
    chk("nwrites", wlog.size(), m_nw);
    for (int i = 0; i < 256; i++) chk($sformatf("mem[%02h]", i), mem[i], mm[i]);
    post = 0;
    repeat (4) begin
      @(negedge clk);
      post += int'(mem_req);
    end
    chk("post_halt_req", post, 0);
  endtask
  task automatic fill();
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
  endtask
  task automatic gen();
    int kind [16];
    logic [7:0] st [17];
    int a = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 16; i++) begin
      kind[i] = $urandom_range(0, CARRY ? 9 : 8);
      st[i] = 8'(a);
      mem[a] = enc(kind[i], $urandom_range(0, 3), $urandom_range(0, 3));
      a += kind[i] >= 5 ? 2 : 1;
    end
    st[16] = 8'(a);
    for (int i = 0; i < 16; i++)
      if (kind[i] == 5) mem[st[i] + 8'd1] = 8'($urandom_range(8'hC0, 8'hDF));
      else if (kind[i] == 6) mem[st[i] + 8'd1] = 8'($urandom_range(8'hE0, 8'hEF));
      else if (kind[i] >= 7) mem[st[i] + 8'd1] = st[$urandom_range(i + 1, 16)];
    for (int d = 0; d < 4; d++) begin
      mem[a] = enc(6, d, 0);
      mem[a + 1] = 8'(8'hF0 + d);
      a += 2;
    end
    mem[a] = {4'($urandom_range(10, 15)), 4'($urandom_range(0, 15))};
  endtask
  initial begin
    int cyc, n;
    // all registers read back as zero after reset
    fill();
    for (int d = 0; d < 4; d++) begin
      mem[2 * d] = enc(6, d, 0);
      mem[2 * d + 1] = 8'(8'h90 + d);
      mem[8'h90 + d] = 8'hFF;
    end
    exec(0, cyc);
    for (int d = 0; d < 4; d++) chk($sformatf("reset_r%0d", d), mem[8'h90 + d], 8'h00);
    // RD/RD/SUB, not-taken BRZ, SUB to zero, taken BRZ
    fill();
    mem[8'h20] = 8'h05; mem[8'h21] = 8'h03; mem[8'h30] = 8'hEE; mem[8'h31] = 8'hEE;
    mem[0] = enc(5, 0, 0); mem[1] = 8'h20; mem[2] = enc(5, 0, 1); mem[3] = 8'h21;
    mem[4] = enc(2, 1, 0); mem[5] = enc(6, 0, 0); mem[6] = 8'h30;
    mem[7] = enc(8, 0, 0); mem[8] = 8'h50; mem[9] = enc(2, 0, 0);
    mem[10] = enc(8, 0, 0); mem[11] = 8'h40;
    mem[8'h40] = enc(6, 0, 0); mem[8'h41] = 8'h31;
    for (int w = 0; w < 4; w += 3) begin
      for (int i = 0; i < 256; i++) init[i] = mem[i];
      exec(w, cyc);
      chk("sub_r0", mem[8'h30], 8'h02);
      chk("sub_zero", mem[8'h31], 8'h00);
      chk("brz_pc", pc_o, 8'h43);
      for (int i = 0; i < 256; i++) mem[i] = init[i];
    end
    // single write of R2, not-taken BRZ; reset during a stalled write first
    fill();
    mem[8'h60] = 8'hA5; mem[8'h80] = 8'h11;
    mem[0] = enc(5, 0, 2); mem[1] = 8'h60; mem[2] = enc(6, 2, 0); mem[3] = 8'h80;
    mem[4] = enc(8, 0, 0); mem[5] = 8'h10;
    hold_wr = 1; max_wait = 0; reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    wlog.delete();
    for (int i = 0; i < 40 && !(mem_req && mem_we); i++) @(negedge clk);
    chk("midwr_we", mem_we, 1);
    @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("midwr_req", mem_req, 0);
    repeat (2) @(posedge clk);
    chk("midwr_nowrite", wlog.size(), 0);
    chk("midwr_mem", mem[8'h80], 8'h11);
    hold_wr = 0;
    exec(0, cyc);
    chk("wr_count", wlog.size(), 1);
    if (wlog.size() == 1) chk("wr_addr_data", wlog[0], 16'h80A5);
    chk("brz_skip_pc", pc_o, 8'h07);
    chk("wr_cycles", cyc, 12);
    // PC wrap from 0xFF to 0x00, then illegal opcode halts
    fill();
    mem[8'h10] = 8'hF0; mem[8'hFE] = enc(0, 0, 0); mem[8'hFF] = enc(0, 0, 0);
    mem[0] = enc(5, 0, 0); mem[1] = 8'h10; mem[2] = enc(6, 0, 0); mem[3] = 8'h00;
    mem[4] = enc(7, 0, 0); mem[5] = 8'hFE;
    exec(0, cyc);
    n = rlog.size();
    if (n >= 3) begin
      chk("wrap_fe", rlog[n - 3], 8'hFE);
      chk("wrap_ff", rlog[n - 2], 8'hFF);
      chk("wrap_00", rlog[n - 1], 8'h00);
    end else chk("wrap_reads", n, 3);
    chk("wrap_pc", pc_o, 8'h01);
    // 0xFF + 0x01 with BRC
    fill();
    mem[8'h20] = 8'hFF; mem[8'h21] = 8'h01; mem[8'h30] = 8'hEE;
    mem[0] = enc(5, 0, 0); mem[1] = 8'h20; mem[2] = enc(5, 0, 1); mem[3] = 8'h21;
    mem[4] = enc(1, 1, 0); mem[5] = enc(9, 0, 0); mem[6] = 8'h40;
    mem[8'h40] = enc(6, 0, 0); mem[8'h41] = 8'h30; mem[8'h42] = enc(8, 0, 0); mem[8'h43] = 8'h50;
    exec(0, cyc);
`ifdef RISC_CORE_CARRY_EN
    chk("carry_sum", mem[8'h30], 8'h00);
    chk("carry_pc", pc_o, 8'h51);
`else
    chk("op9_untouched", mem[8'h30], 8'hEE);
    chk("op9_halt_pc", pc_o, 8'h06);
`endif
    // random programs, zero-wait then random wait states
    for (int p = 0; p < 6; p++) begin
      gen();
      exec(0, cyc);
      for (int i = 0; i < 256; i++) mem[i] = init[i];
      exec(3, cyc);
    end
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
